// File: rtl/down_counter_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_timer_if
//  Description : Control/status bundle for the down_counter_timer block.
//                master modport : drives LOAD/LOAD_VAL/EN, observes the status
//                slave  modport : the counter itself
//  Signals     : LOAD      load request (sampled on falling CLK edge)
//                LOAD_VAL  start value captured on an accepted LOAD
//                EN        count enable
//                NUM       current count (registered)
//                BUSY      1 while the counter is in RUN (registered)
//                ZERO      combinational NUM==0
//                TC        terminal-count pulse, one CLK period wide
//  Revision    : 1.0 - initial release
// ============================================================================
interface down_counter_timer_if #(
    parameter int WIDTH = 4
) ();
    logic             LOAD;
    logic [WIDTH-1:0] LOAD_VAL;
    logic             EN;
    logic [WIDTH-1:0] NUM;
    logic             BUSY;
    logic             ZERO;
    logic             TC;

    modport master (
        output LOAD, LOAD_VAL, EN,
        input  NUM, BUSY, ZERO, TC
    );

    modport slave (
        input  LOAD, LOAD_VAL, EN,
        output NUM, BUSY, ZERO, TC
    );
endinterface
`default_nettype wire

// File: rtl/down_counter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : down_counter_timer
//  Description : Loadable WIDTH-bit countdown timer with an IDLE/RUN/DONE
//                control FSM. All state changes on the FALLING edge of CLK so
//                it shares a clock domain with the ripple up-counter.
//                Priority at each falling edge: LOAD > EN > hold.
//  Ports       : CLK        clock, registers update on falling edge
//                CLEAR_BAR  asynchronous active-low reset
//                bus        down_counter_timer_if.slave
//                           (LOAD, LOAD_VAL, EN in; NUM, BUSY, ZERO, TC out)
//  Options     : DOWN_COUNTER_TIMER_AUTORELOAD_EN - when defined, reaching the
//                terminal count reloads NUM from the last loaded value and
//                stays in RUN, giving a periodic TC.
//  Parameters  : WIDTH - counter width, legal range 2..16
//  Revision    : 1.0 - initial release
// ============================================================================
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  wire logic               CLK,
    input  wire logic               CLEAR_BAR,
    down_counter_timer_if.slave     bus
);

    localparam logic [WIDTH-1:0] c_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic             tc_q, tc_d;
    logic             busy_q;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] rld_q, rld_d;
`endif

    // Next-state logic. TC defaults low so it can only ever be a one-period
    // pulse unless re-asserted on the following edge.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        tc_d    = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        rld_d   = rld_q;
`endif
        if (bus.LOAD) begin
            // A load restarts from any state; a pending count is dropped
            // silently. A zero start value goes straight to DONE so RUN is
            // never entered with NUM==0.
            num_d   = bus.LOAD_VAL;
            state_d = (bus.LOAD_VAL != '0) ? S_RUN : S_DONE;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            rld_d   = bus.LOAD_VAL;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (bus.EN) begin
                        if (num_q > c_ONE) begin
                            num_d = num_q - c_ONE;
                        end else begin
                            // Terminal count: NUM==1 in RUN.
                            tc_d = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
                            num_d = rld_q;
`else
                            num_d   = '0;
                            state_d = S_DONE;
`endif
                        end
                    end
                end
                S_DONE: begin
                    num_d = '0;
                end
                S_IDLE: begin
                    num_d = num_q;
                end
                default: begin
                    state_d = S_IDLE;
                    num_d   = '0;
                end
            endcase
        end
    end

    // Single state register; BUSY is decoded from the next state so that it
    // is itself a flop and moves on the same edge as the state.
    always_ff @(negedge CLK or negedge CLEAR_BAR) begin
        if (!CLEAR_BAR) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            tc_q    <= 1'b0;
            busy_q  <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            rld_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            tc_q    <= tc_d;
            busy_q  <= (state_d == S_RUN);
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
            rld_q   <= rld_d;
`endif
        end
    end

    assign bus.NUM  = num_q;
    assign bus.BUSY = busy_q;
    assign bus.TC   = tc_q;
    assign bus.ZERO = (num_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_down_counter_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_counter_timer
//  Description : Directed self-checking bench for down_counter_timer. Two
//                instances (WIDTH=4 and WIDTH=8) share clock and reset.
//                Inputs change 1 time unit after the rising CLK edge; outputs
//                are checked there, well away from the falling (active) edge.
//                Build with DOWN_COUNTER_TIMER_AUTORELOAD_EN to exercise the
//                autoreload variant instead of the one-shot sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_down_counter_timer;

    logic CLK       = 1'b0;
    logic CLEAR_BAR = 1'b1;
    int   errors    = 0;
    int   checks    = 0;

    always #5 CLK = ~CLK;

    down_counter_timer_if #(.WIDTH(4)) bus4 ();
    down_counter_timer_if #(.WIDTH(8)) bus8 ();

    down_counter_timer #(.WIDTH(4)) u_dut4 (
        .CLK       (CLK),
        .CLEAR_BAR (CLEAR_BAR),
        .bus       (bus4)
    );

    down_counter_timer #(.WIDTH(8)) u_dut8 (
        .CLK       (CLK),
        .CLEAR_BAR (CLEAR_BAR),
        .bus       (bus8)
    );

    // Advance past one falling edge and land just after the next rising edge.
    task automatic tick();
        @(negedge CLK);
        @(posedge CLK);
        #1;
    endtask

    task automatic drive4(input logic ld, input logic [3:0] val, input logic en);
        bus4.LOAD     = ld;
        bus4.LOAD_VAL = val;
        bus4.EN       = en;
    endtask

    task automatic test_reset();
        CLEAR_BAR = 1'b0;
        #5;
        CLEAR_BAR = 1'b1;
        #1;
        checks++; if (bus4.NUM !== 4'd0) begin errors++; $display("FAIL reset_num got=%0d exp=0", bus4.NUM); end
        checks++; if (bus4.ZERO !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b exp=1", bus4.ZERO); end
        checks++; if (bus4.BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus4.BUSY); end
        checks++; if (bus4.TC !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", bus4.TC); end
        checks++; if (bus8.NUM !== 8'd0) begin errors++; $display("FAIL reset_num8 got=%0d exp=0", bus8.NUM); end
    endtask

    task automatic test_one_shot();
        logic [3:0] exp_num [4] = '{4'd3, 4'd2, 4'd1, 4'd0};
        drive4(1'b1, 4'd4, 1'b1);
        tick();
        checks++; if (bus4.NUM !== 4'd4) begin errors++; $display("FAIL os_load_num got=%0d exp=4", bus4.NUM); end
        checks++; if (bus4.BUSY !== 1'b1) begin errors++; $display("FAIL os_load_busy got=%b exp=1", bus4.BUSY); end
        checks++; if (bus4.TC !== 1'b0) begin errors++; $display("FAIL os_load_tc got=%b exp=0", bus4.TC); end
        drive4(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus4.NUM !== exp_num[i]) begin errors++; $display("FAIL os_num[%0d] got=%0d exp=%0d", i, bus4.NUM, exp_num[i]); end
            checks++; if (bus4.TC !== (i == 3)) begin errors++; $display("FAIL os_tc[%0d] got=%b exp=%b", i, bus4.TC, (i == 3)); end
            checks++; if (bus4.BUSY !== (i != 3)) begin errors++; $display("FAIL os_busy[%0d] got=%b exp=%b", i, bus4.BUSY, (i != 3)); end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus4.NUM !== 4'd0) begin errors++; $display("FAIL os_hold_num[%0d] got=%0d exp=0", i, bus4.NUM); end
            checks++; if (bus4.TC !== 1'b0) begin errors++; $display("FAIL os_hold_tc[%0d] got=%b exp=0", i, bus4.TC); end
            checks++; if (bus4.ZERO !== 1'b1) begin errors++; $display("FAIL os_hold_zero[%0d] got=%b exp=1", i, bus4.ZERO); end
        end
    endtask

    task automatic test_enable_gaps();
        logic       en_seq  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [3:0] exp_num [5] = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
        int         tc_seen = 0;
        drive4(1'b1, 4'd3, 1'b0);
        tick();
        checks++; if (bus4.NUM !== 4'd3) begin errors++; $display("FAIL gap_load_num got=%0d exp=3", bus4.NUM); end
        for (int i = 0; i < 5; i++) begin
            drive4(1'b0, 4'd0, en_seq[i]);
            tick();
            if (bus4.TC === 1'b1) tc_seen++;
            checks++; if (bus4.NUM !== exp_num[i]) begin errors++; $display("FAIL gap_num[%0d] got=%0d exp=%0d", i, bus4.NUM, exp_num[i]); end
        end
        drive4(1'b0, 4'd0, 1'b1);
        tick();
        if (bus4.TC === 1'b1) tc_seen++;
        checks++; if (tc_seen != 1) begin errors++; $display("FAIL gap_tc_count got=%0d exp=1", tc_seen); end
    endtask

    task automatic test_restart();
        drive4(1'b1, 4'd5, 1'b1);
        tick();
        drive4(1'b0, 4'd0, 1'b1);
        tick(); tick(); tick();
        checks++; if (bus4.NUM !== 4'd2) begin errors++; $display("FAIL rs_pre_num got=%0d exp=2", bus4.NUM); end
        // LOAD and EN together: load must win.
        drive4(1'b1, 4'd9, 1'b1);
        tick();
        checks++; if (bus4.NUM !== 4'd9) begin errors++; $display("FAIL rs_reload_num got=%0d exp=9", bus4.NUM); end
        checks++; if (bus4.TC !== 1'b0) begin errors++; $display("FAIL rs_reload_tc got=%b exp=0", bus4.TC); end
        checks++; if (bus4.BUSY !== 1'b1) begin errors++; $display("FAIL rs_reload_busy got=%b exp=1", bus4.BUSY); end
        drive4(1'b1, 4'd0, 1'b1);
        tick();
        checks++; if (bus4.NUM !== 4'd0) begin errors++; $display("FAIL rs_zero_num got=%0d exp=0", bus4.NUM); end
        checks++; if (bus4.BUSY !== 1'b0) begin errors++; $display("FAIL rs_zero_busy got=%b exp=0", bus4.BUSY); end
        checks++; if (bus4.TC !== 1'b0) begin errors++; $display("FAIL rs_zero_tc got=%b exp=0", bus4.TC); end
        checks++; if (bus4.ZERO !== 1'b1) begin errors++; $display("FAIL rs_zero_zero got=%b exp=1", bus4.ZERO); end
        drive4(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus4.NUM !== 4'd0) begin errors++; $display("FAIL rs_done_num[%0d] got=%0d exp=0", i, bus4.NUM); end
            checks++; if (bus4.TC !== 1'b0) begin errors++; $display("FAIL rs_done_tc[%0d] got=%b exp=0", i, bus4.TC); end
        end
    endtask

    task automatic test_full_range();
        logic [3:0] e4;
        logic [7:0] e8;
        drive4(1'b1, 4'd15, 1'b1);
        bus8.LOAD = 1'b1; bus8.LOAD_VAL = 8'd255; bus8.EN = 1'b1;
        tick();
        checks++; if (bus4.NUM !== 4'd15) begin errors++; $display("FAIL fr_load4 got=%0d exp=15", bus4.NUM); end
        checks++; if (bus8.NUM !== 8'd255) begin errors++; $display("FAIL fr_load8 got=%0d exp=255", bus8.NUM); end
        drive4(1'b0, 4'd0, 1'b1);
        bus8.LOAD = 1'b0;
        for (int i = 0; i < 256; i++) begin
            tick();
            e4 = (i < 15) ? 4'(14 - i) : 4'd0;
            e8 = (i < 255) ? 8'(254 - i) : 8'd0;
            checks++; if (bus4.NUM !== e4) begin errors++; $display("FAIL fr_num4[%0d] got=%0d exp=%0d", i, bus4.NUM, e4); end
            checks++; if (bus4.TC !== (i == 14)) begin errors++; $display("FAIL fr_tc4[%0d] got=%b exp=%b", i, bus4.TC, (i == 14)); end
            checks++; if (bus8.NUM !== e8) begin errors++; $display("FAIL fr_num8[%0d] got=%0d exp=%0d", i, bus8.NUM, e8); end
            checks++; if (bus8.TC !== (i == 254)) begin errors++; $display("FAIL fr_tc8[%0d] got=%b exp=%b", i, bus8.TC, (i == 254)); end
        end
        bus8.EN = 1'b0;
    endtask

    task automatic test_autoreload();
        logic [3:0] e4;
        drive4(1'b1, 4'd3, 1'b1);
        tick();
        checks++; if (bus4.NUM !== 4'd3) begin errors++; $display("FAIL ar_load_num got=%0d exp=3", bus4.NUM); end
        drive4(1'b0, 4'd0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            e4 = 4'(3 - (k % 3));
            checks++; if (bus4.NUM !== e4) begin errors++; $display("FAIL ar_num[%0d] got=%0d exp=%0d", k, bus4.NUM, e4); end
            checks++; if (bus4.TC !== ((k % 3) == 0)) begin errors++; $display("FAIL ar_tc[%0d] got=%b exp=%b", k, bus4.TC, ((k % 3) == 0)); end
            checks++; if (bus4.BUSY !== 1'b1) begin errors++; $display("FAIL ar_busy[%0d] got=%b exp=1", k, bus4.BUSY); end
        end
        drive4(1'b1, 4'd1, 1'b1);
        tick();
        checks++; if (bus4.TC !== 1'b0) begin errors++; $display("FAIL ar1_load_tc got=%b exp=0", bus4.TC); end
        drive4(1'b0, 4'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (bus4.NUM !== 4'd1) begin errors++; $display("FAIL ar1_num[%0d] got=%0d exp=1", k, bus4.NUM); end
            checks++; if (bus4.TC !== 1'b1) begin errors++; $display("FAIL ar1_tc[%0d] got=%b exp=1", k, bus4.TC); end
        end
    endtask

    task automatic test_async_reset();
        drive4(1'b1, 4'd5, 1'b0);
        tick();
        checks++; if (bus4.NUM !== 4'd5) begin errors++; $display("FAIL ar_pre_num got=%0d exp=5", bus4.NUM); end
        drive4(1'b0, 4'd0, 1'b0);
        // Assert reset mid-phase: no falling CLK edge occurs before the check.
        #2;
        CLEAR_BAR = 1'b0;
        #1;
        checks++; if (bus4.NUM !== 4'd0) begin errors++; $display("FAIL async_num got=%0d exp=0", bus4.NUM); end
        checks++; if (bus4.BUSY !== 1'b0) begin errors++; $display("FAIL async_busy got=%b exp=0", bus4.BUSY); end
        checks++; if (bus4.ZERO !== 1'b1) begin errors++; $display("FAIL async_zero got=%b exp=1", bus4.ZERO); end
        CLEAR_BAR = 1'b1;
        // Back in IDLE: EN alone must not start anything.
        drive4(1'b0, 4'd0, 1'b1);
        tick();
        checks++; if (bus4.NUM !== 4'd0) begin errors++; $display("FAIL async_idle_num got=%0d exp=0", bus4.NUM); end
        checks++; if (bus4.BUSY !== 1'b0) begin errors++; $display("FAIL async_idle_busy got=%b exp=0", bus4.BUSY); end
    endtask

    initial begin
        drive4(1'b0, 4'd0, 1'b0);
        bus8.LOAD = 1'b0; bus8.LOAD_VAL = 8'd0; bus8.EN = 1'b0;
        test_reset();
`ifdef DOWN_COUNTER_TIMER_AUTORELOAD_EN
        test_autoreload();
`else
        test_one_shot();
        test_enable_gaps();
        test_full_range();
`endif
        test_restart();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
